// File: rtl/sd_fifo_wb_host_if.sv
// ============================================================================
// Module   : sd_fifo_wb_host_if
// Brief    : Wishbone master port bundle between the SD FIFO host and the
//            FIFO/status responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sd_fifo_wb_host_if;
  logic [2:0] m_wb_adr_o;
  logic [7:0] m_wb_dat_o;
  logic [7:0] m_wb_dat_i;
  logic       m_wb_we_o;
  logic [3:0] m_wb_sel_o;
  logic       m_wb_cyc_o;
  logic       m_wb_stb_o;
  logic       m_wb_ack_i;

  modport master (
    output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_cyc_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_cyc_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/sd_fifo_wb_host.sv
// ============================================================================
// Module   : sd_fifo_wb_host
// Brief    : Sends a 6-byte SD command through the responder's tx FIFO and
//            collects a 6- or 17-byte response, with poll and ack timeouts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_fifo_wb_host #(
  parameter int POLL_MAX = 255,
  parameter int ACK_MAX  = 15
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_i,
  input  wire logic         start_i,
  input  wire logic [47:0]  cmd_i,
  input  wire logic         rsp_long_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [135:0]      rsp_o,
  sd_fifo_wb_host_if.master wb
);

  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam int ACK_W  = $clog2(ACK_MAX + 1);

  localparam logic [2:0] c_adr_tx   = 3'd0;
  localparam logic [2:0] c_adr_rx   = 3'd1;
  localparam logic [2:0] c_adr_stat = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL_TX = 3'd1,
    WR_CMD  = 3'd2,
    POLL_RX = 3'd3,
    RD_RSP  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              r_state, w_state;
  logic                r_cyc, w_cyc;
  logic                r_we, w_we;
  logic [2:0]          r_adr, w_adr;
  logic [7:0]          r_dat, w_dat;
  logic [47:0]         r_cmd, w_cmd;
  logic                r_long, w_long;
  logic [4:0]          r_byte, w_byte;
  logic [POLL_W-1:0]   r_poll, w_poll;
  logic [ACK_W-1:0]    r_ackc, w_ackc;
  logic [1:0]          r_err, w_err;
  logic [135:0]        r_rsp, w_rsp;
  logic [7:0]          w_cmd_byte;
  logic [4:0]          w_last;

  always_comb begin
    w_cmd_byte = r_cmd[7:0];
    case (r_byte[2:0])
      3'd0:    w_cmd_byte = r_cmd[47:40];
      3'd1:    w_cmd_byte = r_cmd[39:32];
      3'd2:    w_cmd_byte = r_cmd[31:24];
      3'd3:    w_cmd_byte = r_cmd[23:16];
      3'd4:    w_cmd_byte = r_cmd[15:8];
      default: w_cmd_byte = r_cmd[7:0];
    endcase
  end

  assign w_last = r_long ? 5'd16 : 5'd5;

  always_comb begin
    w_state = r_state;
    w_cyc   = r_cyc;
    w_we    = r_we;
    w_adr   = r_adr;
    w_dat   = r_dat;
    w_cmd   = r_cmd;
    w_long  = r_long;
    w_byte  = r_byte;
    w_poll  = r_poll;
    w_ackc  = r_ackc;
    w_err   = r_err;
    w_rsp   = r_rsp;

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_cmd   = cmd_i;
          w_long  = rsp_long_i;
          w_rsp   = '0;
          w_err   = 2'b00;
          w_byte  = '0;
          w_poll  = '0;
          w_state = POLL_TX;
        end
      end

      DONE: w_state = IDLE;

      default: begin
        // Bus is idle here for exactly the cycle after each ack, so
        // issuing immediately still leaves the required gap.
        if (!r_cyc) begin
          w_cyc  = 1'b1;
          w_ackc = '0;
          case (r_state)
            WR_CMD: begin
              w_adr = c_adr_tx;
              w_we  = 1'b1;
              w_dat = w_cmd_byte;
            end
            RD_RSP:  w_adr = c_adr_rx;
            default: w_adr = c_adr_stat;
          endcase
        end else if (wb.m_wb_ack_i) begin
          w_cyc = 1'b0;
          w_we  = 1'b0;
          w_adr = '0;
          w_dat = '0;
          case (r_state)
            POLL_TX, POLL_RX: begin
              if ((r_state == POLL_TX) ? wb.m_wb_dat_i[0] : wb.m_wb_dat_i[1]) begin
                if (r_poll == POLL_W'(POLL_MAX - 1)) begin
                  w_err   = 2'b01;
                  w_state = DONE;
                end else begin
                  w_poll = r_poll + 1'b1;
                end
              end else begin
                w_poll  = '0;
                w_state = (r_state == POLL_TX) ? WR_CMD : RD_RSP;
              end
            end
            WR_CMD: begin
              if (r_byte == 5'd5) begin
                w_byte  = '0;
                w_poll  = '0;
                w_state = POLL_RX;
              end else begin
                w_byte  = r_byte + 5'd1;
                w_state = POLL_TX;
              end
            end
            RD_RSP: begin
              w_rsp = {r_rsp[127:0], wb.m_wb_dat_i};
              if (r_byte == w_last) begin
                w_state = DONE;
              end else begin
                w_byte  = r_byte + 5'd1;
                w_state = POLL_RX;
              end
            end
            default: w_state = IDLE;
          endcase
        end else if (r_ackc == ACK_W'(ACK_MAX - 1)) begin
          // An ack arriving in this same cycle took the branch above.
          w_cyc   = 1'b0;
          w_we    = 1'b0;
          w_adr   = '0;
          w_dat   = '0;
          w_err   = 2'b10;
          w_state = DONE;
        end else begin
          w_ackc = r_ackc + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_cmd   <= '0;
      r_long  <= 1'b0;
      r_byte  <= '0;
      r_poll  <= '0;
      r_ackc  <= '0;
      r_err   <= 2'b00;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_we    <= w_we;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_cmd   <= w_cmd;
      r_long  <= w_long;
      r_byte  <= w_byte;
      r_poll  <= w_poll;
      r_ackc  <= w_ackc;
      r_err   <= w_err;
      r_rsp   <= w_rsp;
    end
  end

  assign busy_o        = (r_state != IDLE);
  assign done_o        = (r_state == DONE);
  assign err_o         = r_err;
  assign rsp_o         = r_rsp;
  assign wb.m_wb_cyc_o = r_cyc;
  assign wb.m_wb_stb_o = r_cyc;
  assign wb.m_wb_adr_o = r_adr;
  assign wb.m_wb_dat_o = r_dat;
  assign wb.m_wb_we_o  = r_we;
  assign wb.m_wb_sel_o = {3'b000, r_cyc};

endmodule

`default_nettype wire

// File: doc/sd_fifo_wb_host.md
SD_FIFO_WB_HOST -- requirements
Module: sd_fifo_wb_host

Interface
REQ-001 Parameter POLL_MAX, default 255: failed status polls allowed per byte before abort.
REQ-002 Parameter ACK_MAX, default 15: cycles a bus transfer may wait for ack before abort.
REQ-003 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  request to run one command/response transaction.
REQ-006 cmd_i  in  48  command frame; byte 0 = cmd_i[47:40].
REQ-007 rsp_long_i  in  1  0: 6 response bytes; 1: 17 response bytes.
REQ-008 busy_o  out  1  transaction in progress.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 err_o  out  2  00 ok, 01 poll timeout, 10 ack timeout.
REQ-011 rsp_o  out  136  received bytes, shifted in at LSB end.
REQ-012 m_wb_adr_o  out  3  responder register address.
REQ-013 m_wb_dat_o  out  8  write data.
REQ-014 m_wb_dat_i  in  8  read data.
REQ-015 m_wb_we_o  out  1  write enable.
REQ-016 m_wb_sel_o  out  4  byte select, constant 4'b0001 during transfers.
REQ-017 m_wb_cyc_o / m_wb_stb_o  out  1 each  cycle and strobe, always driven equal.
REQ-018 m_wb_ack_i  in  1  acknowledge.

Function
REQ-019 Register map: 0 tx command FIFO (W), 1 rx command FIFO (R), 4 status (R); status bit0 = tx cmd FIFO full, bit1 = rx cmd FIFO empty.
REQ-020 States: IDLE, POLL_TX, WR_CMD, POLL_RX, RD_RSP, DONE.
REQ-021 IDLE: start_i=1 latches cmd_i and rsp_long_i, clears rsp_o, byte and poll counters, enters POLL_TX; busy_o=1 from next cycle.
REQ-022 start_i while not IDLE is ignored; latched cmd/length stay stable.
REQ-023 Transfer: cyc/stb/adr/we/dat/sel asserted together, held stable until ack; data sampled in ack cycle; cyc/stb low the cycle after ack; at least one idle cycle between transfers.
REQ-024 POLL_TX: read adr 4; bit0=1 -> increment poll count, repeat; bit0=0 -> clear poll count, WR_CMD.
REQ-025 WR_CMD: write adr 0, data = command byte k (k=0..5, MSB first); after ack, k<5 -> POLL_TX with k+1, k=5 -> POLL_RX with count 0.
REQ-026 POLL_RX: read adr 4; bit1=1 -> increment poll count, repeat; bit1=0 -> clear poll count, RD_RSP.
REQ-027 RD_RSP: read adr 1; on ack rsp_o <= {rsp_o[127:0], m_wb_dat_i}; count < N-1 -> POLL_RX, else DONE (N=6 or 17).
REQ-028 Poll count reaching POLL_MAX failed polls -> DONE with err_o=01.
REQ-029 Ack counter restarts per transfer; ACK_MAX cycles of stb without ack -> cyc/stb deasserted next cycle, DONE with err_o=10.
REQ-030 DONE: done_o=1 for exactly one cycle, busy_o=0 next cycle, return to IDLE; err_o and rsp_o hold until next accepted start.
REQ-031 Short response occupies rsp_o[47:0]; upper bits zero.
REQ-032 Ack in same cycle as ack-timeout expiry is treated as success.
REQ-033 m_wb_ack_i ignored when cyc/stb low.

Reset
REQ-034 wb_rst_i=1 immediately forces IDLE, cyc/stb/we=0, adr=0, dat=0, sel=0, busy_o=0, done_o=0, err_o=00, rsp_o=0, all counters 0; mid-transfer reset aborts with no further bus activity.

Verification
REQ-035 Start cmd 48'h40_00_00_00_00_95, rsp_long 0, responder status 8'h00, rx bytes 01..06 -> six writes 40,00,00,00,00,95 to adr 0, six reads adr 1, rsp_o[47:0]=48'h010203040506, err 00, one done pulse.
REQ-036 rsp_long 1, 17 rx bytes 11..21 -> rsp_o = 136'h1112..21, 17 RD_RSP transfers.
REQ-037 Status bit0=1 for first 3 polls of byte 0 -> exactly 4 status reads before first write; status bit1 held 1 -> after 255 failed polls, err_o=01, done pulse.
REQ-038 Responder never acks a write -> stb drops after 15 cycles, err_o=10, busy_o low next cycle after done.
REQ-039 Assert wb_rst_i during RD_RSP with stb high -> cyc/stb low same cycle, outputs at reset values; new start afterwards completes normally.
